// File: rtl/bus_mux_reg.sv
// -----------------------------------------------------------------------------
// bus_mux_reg
//   Registered shared-bus multiplexer. One of NUM_SRC source words is chosen
//   from a (nominally one-hot) drive-enable vector and loaded onto the bus one
//   clock later. When several sources drive at once, the lowest index wins and
//   the cycle is flagged and counted as a conflict. When nothing drives, the
//   bus holds its last value.
//
// Optional build macro: BUS_MUX_PARITY_EN adds bus_par, the XOR of the loaded
//   word, which is registered alongside bus_out.
//
// Ports
//   clock         rising-edge clock
//   clear         asynchronous active-low reset
//   src_data      flattened sources, source i at [i*WIDTH +: WIDTH]
//   drive_en      per-source drive request, bit i = source i
//   cnt_clr       synchronous clear of conflict_cnt / err_sticky
//   bus_out       registered bus word
//   bus_valid     bus_out was loaded on the last edge
//   bus_src       index of the source that loaded bus_out
//   conflict      last edge saw more than one drive_en bit set (1-cycle pulse)
//   err_sticky    a conflict has occurred since reset or cnt_clr
//   bus_par       (BUS_MUX_PARITY_EN only) XOR of the loaded word
//   conflict_cnt  saturating count of conflict cycles
// -----------------------------------------------------------------------------
module bus_mux_reg #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 24,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int CNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       drive_en,
    input  logic                     cnt_clr,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     bus_valid,
    output logic [SEL_W-1:0]         bus_src,
    output logic                     conflict,
    output logic                     err_sticky,
`ifdef BUS_MUX_PARITY_EN
    output logic                     bus_par,
`endif
    output logic [CNT_W-1:0]         conflict_cnt
);

    logic [SEL_W-1:0] winIdx;
    logic [WIDTH-1:0] winWord;
    logic             anyDrive;
    logic             multiDrive;
    logic             cntFull;

    // Priority encode: scan from the top down so the lowest set index is the
    // last assignment and therefore wins.
    always_comb begin
        winIdx  = '0;
        winWord = src_data[WIDTH-1:0];
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (drive_en[i]) begin
                winIdx  = SEL_W'(i);
                winWord = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // x & (x-1) clears the lowest set bit; anything left means >1 driver.
    assign anyDrive   = |drive_en;
    assign multiDrive = |(drive_en & (drive_en - NUM_SRC'(1)));
    assign cntFull    = &conflict_cnt;

    // Bus datapath: loads only when someone drives, holds otherwise.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_out   <= '0;
            bus_src   <= '0;
            bus_valid <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            bus_valid <= anyDrive;
            conflict  <= multiDrive;
            if (anyDrive) begin
                bus_out <= winWord;
                bus_src <= winIdx;
            end
        end
    end

    // Conflict bookkeeping: cnt_clr has priority over set/increment, but the
    // conflict pulse above is unaffected by it.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            err_sticky   <= 1'b0;
            conflict_cnt <= '0;
        end else if (cnt_clr) begin
            err_sticky   <= 1'b0;
            conflict_cnt <= '0;
        end else if (multiDrive) begin
            err_sticky <= 1'b1;
            if (!cntFull) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

`ifdef BUS_MUX_PARITY_EN
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_par <= 1'b0;
        end else if (anyDrive) begin
            bus_par <= ^winWord;
        end
    end
`endif

endmodule
